// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC output-port allocator.
package noc_alloc_pkg;

  typedef enum logic [0:0] {IDLE, XFER} alloc_state_t;

  localparam int unsigned NUM_IN_DFLT     = 4;
  localparam int unsigned CRED_DEPTH_DFLT = 4;
  localparam int unsigned SEL_W           = $clog2(NUM_IN_DFLT);
  localparam int unsigned CRED_W          = $clog2(CRED_DEPTH_DFLT + 1);
  localparam int unsigned PICK_W          = 32;

  // Lowest-index set bit; returns 0 for an all-zero vector.
  function automatic int unsigned first_set_idx(input logic [PICK_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = int'(PICK_W) - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_out_port_alloc_if.sv
// Handshake bundle between input buffers / downstream credits and the output-port allocator.
// Carries the starve vector only when NOC_ALLOC_WAITMON_EN is defined.
interface noc_out_port_alloc_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned CRED_DEPTH = 4
);
  localparam int unsigned SelW  = $clog2(NUM_IN);
  localparam int unsigned CredW = $clog2(CRED_DEPTH + 1);

  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_tail;
  logic [NUM_IN-1:0] in_ready;
  logic              out_valid;
  logic              out_tail;
  logic [SelW-1:0]   out_sel;
  logic [NUM_IN-1:0] grant;
  logic              credit_in;
  logic [CredW-1:0]  credit_cnt;
  logic              err_credit;
`ifdef NOC_ALLOC_WAITMON_EN
  logic [NUM_IN-1:0] starve;

  modport master (
    output in_valid, in_tail, credit_in,
    input  in_ready, out_valid, out_tail, out_sel, grant, credit_cnt, err_credit, starve
  );
  modport slave (
    input  in_valid, in_tail, credit_in,
    output in_ready, out_valid, out_tail, out_sel, grant, credit_cnt, err_credit, starve
  );
`else
  modport master (
    output in_valid, in_tail, credit_in,
    input  in_ready, out_valid, out_tail, out_sel, grant, credit_cnt, err_credit
  );
  modport slave (
    input  in_valid, in_tail, credit_in,
    output in_ready, out_valid, out_tail, out_sel, grant, credit_cnt, err_credit
  );
`endif

endinterface

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: lowest request inside the priority mask, else lowest request.
module rr_prio_pick
  import noc_alloc_pkg::*;
#(
  parameter int unsigned NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [NUM_IN-1:0]         pr,
  output logic [$clog2(NUM_IN)-1:0] idx,
  output logic [NUM_IN-1:0]         onehot,
  output logic                      any
);
  localparam int unsigned SelW = $clog2(NUM_IN);

  logic [NUM_IN-1:0] masked;
  logic [PICK_W-1:0] pick_vec;

  always_comb begin
    masked   = req & pr;
    pick_vec = '0;
    pick_vec[NUM_IN-1:0] = (masked != '0) ? masked : req;
    any      = |req;
    idx      = SelW'(first_set_idx(pick_vec));
    onehot   = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/noc_out_port_alloc.sv
// Packet-locked round-robin output-port allocator with downstream credit gating.
// Optional per-input starvation monitor enabled by NOC_ALLOC_WAITMON_EN.
module noc_out_port_alloc
  import noc_alloc_pkg::*;
#(
  parameter int unsigned NUM_IN     = NUM_IN_DFLT,
  parameter int unsigned CRED_DEPTH = CRED_DEPTH_DFLT,
  parameter int unsigned MAX_WAIT   = 15
) (
  input logic                 clk,
  input logic                 reset,
  noc_out_port_alloc_if.slave bus
);
  localparam int unsigned      SelW    = $clog2(NUM_IN);
  localparam int unsigned      CredW   = $clog2(CRED_DEPTH + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(CRED_DEPTH);
  localparam logic [CredW-1:0] CredOne = CredW'(1);

  alloc_state_t      state_q;
  logic [NUM_IN-1:0] grant_q;
  logic [NUM_IN-1:0] pr_q;
  logic [NUM_IN-1:0] pr_next;
  logic [NUM_IN-1:0] win_onehot;
  logic [SelW-1:0]   sel_q;
  logic [SelW-1:0]   win_idx;
  logic              win_any;
  logic              can_send;
  logic              xfer;
  logic              xfer_tail;
  logic [CredW-1:0]  credit_q, credit_d;
  logic              err_q, err_d;

  rr_prio_pick #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req    (bus.in_valid),
    .pr     (pr_q),
    .idx    (win_idx),
    .onehot (win_onehot),
    .any    (win_any)
  );

  always_comb begin
    can_send  = (credit_q != '0);
    xfer      = (state_q == XFER) && bus.in_valid[sel_q] && can_send;
    xfer_tail = xfer && bus.in_tail[sel_q];
    // Priority goes to the inputs strictly above the winner.
    pr_next   = ~((win_onehot << 1) - NUM_IN'(1));
  end

  assign bus.in_ready   = grant_q & {NUM_IN{xfer}};
  assign bus.out_valid  = xfer;
  assign bus.out_tail   = xfer_tail;
  assign bus.out_sel    = sel_q;
  assign bus.grant      = grant_q;
  assign bus.credit_cnt = credit_q;
  assign bus.err_credit = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      pr_q    <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any && can_send) begin
            grant_q <= win_onehot;
            sel_q   <= win_idx;
            pr_q    <= pr_next;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (xfer_tail) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A returned credit only becomes usable on the following cycle.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({xfer, bus.credit_in})
      2'b10: credit_d = credit_q - CredOne;
      2'b01: begin
        if (credit_q == CredMax) err_d = 1'b1;
        else                     credit_d = credit_q + CredOne;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= CredMax;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

`ifdef NOC_ALLOC_WAITMON_EN
  localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 2);
  localparam logic [WaitW-1:0] WaitSat = WaitW'(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  logic [NUM_IN-1:0][WaitW-1:0] wait_q, wait_d;
  logic [NUM_IN-1:0]            starve_q, starve_d;

  always_comb begin
    for (int i = 0; i < int'(NUM_IN); i++) begin
      wait_d[i] = '0;
      if (bus.in_valid[i] && !grant_q[i]) begin
        wait_d[i] = (wait_q[i] == WaitSat) ? WaitSat : wait_q[i] + WaitW'(1);
      end
      starve_d[i] = (wait_d[i] > WaitMax);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign bus.starve = starve_q;
`endif

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.in_ready));
  a_ready_valid:   assert property (@(posedge clk) disable iff (reset)
                                    (bus.in_ready & ~bus.in_valid) == '0);
  a_credit_max:    assert property (@(posedge clk) disable iff (reset) credit_q <= CredMax);

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Self-checking bench for noc_out_port_alloc: vector table plus flit scoreboard.
module tb_noc_out_port_alloc;
  import noc_alloc_pkg::*;

  localparam int unsigned NIn = 4;

  typedef struct {
    logic [NIn-1:0]    valid;
    logic [NIn-1:0]    tail;
    logic              credit;
    logic              exp_ov;
    logic [NIn-1:0]    exp_ready;
    logic [SEL_W-1:0]  exp_sel;
    logic [NIn-1:0]    exp_grant;
    logic [CRED_W-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             tail;
  } flit_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_checks = 0;
  int    n_fail = 0;
  flit_t exp_q[$];
  vec_t  rr_tbl[11];

  noc_out_port_alloc_if #(.NUM_IN(NIn), .CRED_DEPTH(4)) bus ();

  noc_out_port_alloc #(
    .NUM_IN     (NIn),
    .CRED_DEPTH (4),
    .MAX_WAIT   (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transferred flit must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_flit: got sel %0d expected none", bus.out_sel);
      end else begin
        flit_t f;
        f = exp_q.pop_front();
        chk("sb_sel", 32'(bus.out_sel), 32'(f.sel));
        chk("sb_tail", 32'(bus.out_tail), 32'(f.tail));
      end
    end
  end

  // Drive one cycle's inputs just after the edge, queue the expected flit, settle to mid-cycle.
  task automatic cyc(input logic [NIn-1:0] v, input logic [NIn-1:0] t, input logic c,
                     input logic ef, input logic [SEL_W-1:0] es, input logic et);
    flit_t f;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_tail   = t;
    bus.credit_in = c;
    if (ef) begin
      f.sel  = es;
      f.tail = et;
      exp_q.push_back(f);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_tail   = '0;
    bus.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    rr_tbl[0]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 3'd4};
    rr_tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 3'd4};
    rr_tbl[2]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 3'd4};
    rr_tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 2'd1, 4'h2, 3'd4};
    rr_tbl[4]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 2'd1, 4'h0, 3'd4};
    rr_tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 2'd2, 4'h4, 3'd4};
    rr_tbl[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 2'd2, 4'h0, 3'd4};
    rr_tbl[7]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 2'd3, 4'h8, 3'd4};
    rr_tbl[8]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 2'd3, 4'h0, 3'd4};
    rr_tbl[9]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 3'd4};
    rr_tbl[10] = '{4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 3'd4};

    // Reset values, with requests present to show combinational outputs are held low.
    reset         = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_tail   = 4'hF;
    bus.credit_in = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_out_sel", 32'(bus.out_sel), 0);
    chk("rst_credit", 32'(bus.credit_cnt), 4);
    chk("rst_err", 32'(bus.err_credit), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    do_reset();

    // Single-flit round robin.
    foreach (rr_tbl[i]) begin
      cyc(rr_tbl[i].valid, rr_tbl[i].tail, rr_tbl[i].credit,
          rr_tbl[i].exp_ov, rr_tbl[i].exp_sel, 1'b1);
      chk($sformatf("rr%0d_out_valid", i), 32'(bus.out_valid), 32'(rr_tbl[i].exp_ov));
      chk($sformatf("rr%0d_in_ready", i), 32'(bus.in_ready), 32'(rr_tbl[i].exp_ready));
      chk($sformatf("rr%0d_out_sel", i), 32'(bus.out_sel), 32'(rr_tbl[i].exp_sel));
      chk($sformatf("rr%0d_grant", i), 32'(bus.grant), 32'(rr_tbl[i].exp_grant));
      chk($sformatf("rr%0d_credit", i), 32'(bus.credit_cnt), 32'(rr_tbl[i].exp_cnt));
    end
    chk("rr_err", 32'(bus.err_credit), 0);

    // Packet lock with a bubble; input 1 first moves priority past input 0.
    do_reset();
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    chk("lock_pre_sel", 32'(bus.out_sel), 1);
    cyc(4'b0101, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("lock_gap_grant", 32'(bus.grant), 0);
    cyc(4'b0101, 4'b0001, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("lock_f1_ready", 32'(bus.in_ready), 32'b0100);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("lock_bubble_ov", 32'(bus.out_valid), 0);
    chk("lock_bubble_grant", 32'(bus.grant), 32'b0100);
    chk("lock_bubble_ready", 32'(bus.in_ready), 0);
    cyc(4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2, 1'b0);
    chk("lock_f2_ready", 32'(bus.in_ready), 32'b0100);
    chk("lock_f2_credit", 32'(bus.credit_cnt), 2);
    cyc(4'b0101, 4'b0101, 1'b0, 1'b1, 2'd2, 1'b1);
    chk("lock_xfer_credit_same", 32'(bus.credit_cnt), 2);
    chk("lock_f3_sel", 32'(bus.out_sel), 2);
    cyc(4'b1001, 4'b1001, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("lock_after_grant", 32'(bus.grant), 0);
    cyc(4'b1001, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b1);
    chk("lock_next_grant", 32'(bus.grant), 32'b1000);
    chk("lock_next_sel", 32'(bus.out_sel), 3);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("lock_end_credit", 32'(bus.credit_cnt), 0);

    // Credit stall, single-credit release, then overflow error.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
      chk($sformatf("stall_f%0d_credit", k), 32'(bus.credit_cnt), 32'(4 - k));
    end
    cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("stall_ov", 32'(bus.out_valid), 0);
    chk("stall_credit", 32'(bus.credit_cnt), 0);
    chk("stall_grant", 32'(bus.grant), 32'b0010);
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("stall_no_bypass", 32'(bus.out_valid), 0);
    cyc(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("stall_release_ov", 32'(bus.out_valid), 1);
    chk("stall_release_credit", 32'(bus.credit_cnt), 1);
    cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("stall_again_ov", 32'(bus.out_valid), 0);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    chk("stall_tail", 32'(bus.out_tail), 1);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("stall_end_grant", 32'(bus.grant), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
      chk($sformatf("refill%0d_credit", k), 32'(bus.credit_cnt), 32'(k));
    end
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("ovf_pre_err", 32'(bus.err_credit), 0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("ovf_credit_sat", 32'(bus.credit_cnt), 4);
    chk("ovf_err", 32'(bus.err_credit), 1);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("ovf_err_sticky", 32'(bus.err_credit), 1);

    // Reset in the middle of input 3's packet.
    do_reset();
    cyc(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("mid_f1_sel", 32'(bus.out_sel), 3);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.in_valid = 4'b1010;
    bus.in_tail  = 4'b0010;
    @(negedge clk);
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_credit", 32'(bus.credit_cnt), 4);
    chk("mid_rst_ov", 32'(bus.out_valid), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_idle_ov", 32'(bus.out_valid), 0);
    cyc(4'b1010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    chk("mid_winner_grant", 32'(bus.grant), 32'b0010);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

`ifdef NOC_ALLOC_WAITMON_EN
    // Input 1 waits behind a 20-flit packet from input 0.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      cyc((c == 23) ? 4'b0000 : 4'b0011, (c == 20) ? 4'b0011 : 4'b0010,
          (c >= 1 && c <= 20), (c >= 1 && c <= 20) || c == 22,
          (c == 22) ? 2'd1 : 2'd0, (c == 20) || (c == 22));
      if (c == 15) chk("wm_starve_15", 32'(bus.starve[1]), 0);
      if (c == 16) chk("wm_starve_16", 32'(bus.starve[1]), 1);
      if (c == 22) begin
        chk("wm_grant1", 32'(bus.grant), 32'b0010);
        chk("wm_starve_at_grant", 32'(bus.starve[1]), 1);
      end
      if (c == 23) chk("wm_starve_clear", 32'(bus.starve[1]), 0);
    end
`endif

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
